// File: rtl/aukv_decode.sv
// aukv_decode: Auk-V RV32I decode stage; decodes the fetched word and registers it into the decode/execute register.
//    i_clk, i_rstn (async, active-low)           clock and reset
//    i_pc, i_instr, i_instr_valid                fetch interface (i_pc is instruction address + 4)
//    i_stall, i_flush                            hold / kill the capture (flush wins)
//    o_rs1_addr, o_rs2_addr                      combinational register-file read addresses
//    o_valid, o_instr, o_pc, o_link, o_rd_addr   registered instruction identity
//    o_imm, o_funct3, o_alu_op, o_src_*          registered execute controls
//    o_reg_we, o_mem_*, o_branch, o_jal*, o_illegal registered writeback/memory/control-flow class
module aukv_decode #(
   parameter logic [31:0] NOP_INSTR = 32'h00000033
) (
   input  logic        i_clk,
   input  logic        i_rstn,
   input  logic [31:0] i_pc,
   input  logic [31:0] i_instr,
   input  logic        i_instr_valid,
   input  logic        i_stall,
   input  logic        i_flush,
   output logic [4:0]  o_rs1_addr,
   output logic [4:0]  o_rs2_addr,
   output logic        o_valid,
   output logic [31:0] o_instr,
   output logic [31:0] o_pc,
   output logic [31:0] o_link,
   output logic [4:0]  o_rd_addr,
   output logic [31:0] o_imm,
   output logic [2:0]  o_funct3,
   output logic [3:0]  o_alu_op,
   output logic        o_src_a_pc,
   output logic        o_src_b_imm,
   output logic        o_reg_we,
   output logic        o_mem_rd,
   output logic        o_mem_wr,
   output logic        o_branch,
   output logic        o_jal,
   output logic        o_jalr,
   output logic        o_illegal
);
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_MISC   = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_SLL  = 4'd2;
   localparam logic [3:0] ALU_SLT  = 4'd3;
   localparam logic [3:0] ALU_SLTU = 4'd4;
   localparam logic [3:0] ALU_XOR  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_OR   = 4'd8;
   localparam logic [3:0] ALU_AND  = 4'd9;
   localparam logic [3:0] ALU_PASS = 4'd10;
   localparam logic [6:0] F7_ALT   = 7'b0100000;

   typedef struct packed {
      logic        valid;
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] link;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic [2:0]  funct3;
      logic [3:0]  alu_op;
      logic        src_a_pc;
      logic        src_b_imm;
      logic        reg_we;
      logic        mem_rd;
      logic        mem_wr;
      logic        branch;
      logic        jal;
      logic        jalr;
      logic        illegal;
   } dx_t;

   localparam dx_t BUBBLE = '{valid: 1'b0, instr: NOP_INSTR, pc: 32'd0, link: 32'd0, rd: 5'd0,
                              imm: 32'd0, funct3: 3'd0, alu_op: 4'd0, src_a_pc: 1'b0,
                              src_b_imm: 1'b0, reg_we: 1'b0, mem_rd: 1'b0, mem_wr: 1'b0,
                              branch: 1'b0, jal: 1'b0, jalr: 1'b0, illegal: 1'b0};

   // alt selects SUB for funct3=0 and SRA for funct3=5
   function automatic logic [3:0] alu_of(input logic [2:0] f, input logic alt);
      case (f)
         3'd0: return alt ? ALU_SUB : ALU_ADD;
         3'd1: return ALU_SLL;
         3'd2: return ALU_SLT;
         3'd3: return ALU_SLTU;
         3'd4: return ALU_XOR;
         3'd5: return alt ? ALU_SRA : ALU_SRL;
         3'd6: return ALU_OR;
         3'd7: return ALU_AND;
      endcase
   endfunction

   logic [6:0] opc;
   logic [2:0] f3;
   logic [6:0] f7;
   dx_t        dec;
   dx_t        dx_d;
   dx_t        dx_q;

   assign opc        = i_instr[6:0];
   assign f3         = i_instr[14:12];
   assign f7         = i_instr[31:25];
   assign o_rs1_addr = i_instr[19:15];
   assign o_rs2_addr = i_instr[24:20];

   always_comb begin
      dec        = '0;
      dec.valid  = 1'b1;
      dec.instr  = i_instr;
      dec.pc     = i_pc - 32'd4;
      dec.link   = i_pc;
      dec.rd     = i_instr[11:7];
      dec.funct3 = f3;
      case (opc)
         OPC_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM:
            dec.imm = {{20{i_instr[31]}}, i_instr[31:20]};
         OPC_STORE:
            dec.imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
         OPC_BRANCH:
            dec.imm = {{20{i_instr[31]}}, i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
         OPC_LUI, OPC_AUIPC:
            dec.imm = {i_instr[31:12], 12'd0};
         OPC_JAL:
            dec.imm = {{12{i_instr[31]}}, i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
         default:
            dec.imm = '0;
      endcase
      case (opc)
         OPC_OP: begin
            dec.alu_op  = alu_of(f3, f7[5]);
            dec.reg_we  = 1'b1;
            dec.illegal = !(f7 == '0 || (f7 == F7_ALT && (f3 == 3'd0 || f3 == 3'd5)));
         end
         OPC_IMM: begin
            // only the right shifts carry an alternate form (SRAI)
            dec.alu_op    = alu_of(f3, f3 == 3'd5 && i_instr[30]);
            dec.src_b_imm = 1'b1;
            dec.reg_we    = 1'b1;
            dec.illegal   = (f3 == 3'd1 && f7 != '0) || (f3 == 3'd5 && f7 != '0 && f7 != F7_ALT);
         end
         OPC_LOAD: begin
            dec.src_b_imm = 1'b1;
            dec.mem_rd    = 1'b1;
            dec.reg_we    = 1'b1;
            dec.illegal   = f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7;
         end
         OPC_STORE: begin
            dec.src_b_imm = 1'b1;
            dec.mem_wr    = 1'b1;
            dec.illegal   = f3 > 3'd2;
         end
         OPC_BRANCH: begin
            dec.branch  = 1'b1;
            dec.alu_op  = ALU_SUB;
            dec.illegal = f3[2:1] == 2'b01;
         end
         OPC_LUI: begin
            dec.alu_op    = ALU_PASS;
            dec.src_b_imm = 1'b1;
            dec.reg_we    = 1'b1;
         end
         OPC_AUIPC: begin
            dec.src_a_pc  = 1'b1;
            dec.src_b_imm = 1'b1;
            dec.reg_we    = 1'b1;
         end
         OPC_JAL: begin
            dec.jal       = 1'b1;
            dec.src_a_pc  = 1'b1;
            dec.src_b_imm = 1'b1;
            dec.reg_we    = 1'b1;
         end
         OPC_JALR: begin
            dec.jalr      = 1'b1;
            dec.src_b_imm = 1'b1;
            dec.reg_we    = 1'b1;
         end
         OPC_MISC, OPC_SYSTEM: begin
            dec.alu_op = ALU_ADD;
         end
         default: begin
            dec.illegal = 1'b1;
         end
      endcase
      // an illegal instruction travels as valid but must have no side effects
      if (dec.illegal)
         {dec.alu_op, dec.src_a_pc, dec.src_b_imm, dec.reg_we, dec.mem_rd, dec.mem_wr,
          dec.branch, dec.jal, dec.jalr} = '0;
      if (dec.rd == 5'd0)
         dec.reg_we = 1'b0;
   end

   always_comb
      dx_d = (i_flush || (!i_stall && !i_instr_valid)) ? BUBBLE : i_stall ? dx_q : dec;

   always_ff @(posedge i_clk or negedge i_rstn)
      if (!i_rstn)
         dx_q <= BUBBLE;
      else
         dx_q <= dx_d;

   assign o_valid     = dx_q.valid;
   assign o_instr     = dx_q.instr;
   assign o_pc        = dx_q.pc;
   assign o_link      = dx_q.link;
   assign o_rd_addr   = dx_q.rd;
   assign o_imm       = dx_q.imm;
   assign o_funct3    = dx_q.funct3;
   assign o_alu_op    = dx_q.alu_op;
   assign o_src_a_pc  = dx_q.src_a_pc;
   assign o_src_b_imm = dx_q.src_b_imm;
   assign o_reg_we    = dx_q.reg_we;
   assign o_mem_rd    = dx_q.mem_rd;
   assign o_mem_wr    = dx_q.mem_wr;
   assign o_branch    = dx_q.branch;
   assign o_jal       = dx_q.jal;
   assign o_jalr      = dx_q.jalr;
   assign o_illegal   = dx_q.illegal;
endmodule

// File: tb/tb_aukv_decode.sv
// tb_aukv_decode: directed and randomized checks of aukv_decode against a behavioural decode model.
module tb_aukv_decode;
   logic        i_clk = 1'b0;
   logic        i_rstn;
   logic [31:0] i_pc;
   logic [31:0] i_instr;
   logic        i_instr_valid;
   logic        i_stall;
   logic        i_flush;
   logic [4:0]  o_rs1_addr, o_rs2_addr, o_rd_addr;
   logic        o_valid, o_src_a_pc, o_src_b_imm, o_reg_we, o_mem_rd, o_mem_wr;
   logic        o_branch, o_jal, o_jalr, o_illegal;
   logic [31:0] o_instr, o_pc, o_link, o_imm;
   logic [2:0]  o_funct3;
   logic [3:0]  o_alu_op;

   aukv_decode dut (
      .i_clk(i_clk), .i_rstn(i_rstn), .i_pc(i_pc), .i_instr(i_instr),
      .i_instr_valid(i_instr_valid), .i_stall(i_stall), .i_flush(i_flush),
      .o_rs1_addr(o_rs1_addr), .o_rs2_addr(o_rs2_addr), .o_valid(o_valid),
      .o_instr(o_instr), .o_pc(o_pc), .o_link(o_link), .o_rd_addr(o_rd_addr),
      .o_imm(o_imm), .o_funct3(o_funct3), .o_alu_op(o_alu_op),
      .o_src_a_pc(o_src_a_pc), .o_src_b_imm(o_src_b_imm), .o_reg_we(o_reg_we),
      .o_mem_rd(o_mem_rd), .o_mem_wr(o_mem_wr), .o_branch(o_branch),
      .o_jal(o_jal), .o_jalr(o_jalr), .o_illegal(o_illegal)
   );

   always #5 i_clk = ~i_clk;

   // {valid, instr, pc, link, rd, imm, funct3, alu_op, src_a, src_b, we, mem_rd, mem_wr, br, jal, jalr, illegal}
   localparam logic [149:0] BUB      = {1'b0, 32'h00000033, 117'd0};
   localparam logic [149:0] ILL_KEEP = ~(150'h3F << 7);

   int          errors = 0;
   int          checks = 0;
   logic [149:0] obs, expq, held;

   assign obs = {o_valid, o_instr, o_pc, o_link, o_rd_addr, o_imm, o_funct3, o_alu_op,
                 o_src_a_pc, o_src_b_imm, o_reg_we, o_mem_rd, o_mem_wr, o_branch,
                 o_jal, o_jalr, o_illegal};

   // ALU selection is unconstrained for an illegal instruction
   function automatic logic [149:0] keep(input logic [149:0] e);
      return e[0] ? ILL_KEEP : {150{1'b1}};
   endfunction

   function automatic logic [149:0] ref_dec(input logic [31:0] ins, input logic [31:0] pc);
      logic [6:0]  op = ins[6:0];
      logic [2:0]  f3 = ins[14:12];
      logic [6:0]  f7 = ins[31:25];
      logic [31:0] imm = 32'd0;
      logic [3:0]  alu = 4'd0;
      logic        sa = 0, sb = 0, we = 0, mrd = 0, mwr = 0, br = 0, j = 0, jr = 0, ill = 0;
      int          base [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
      case (op)
         7'h13, 7'h03, 7'h67, 7'h73: imm = 32'($signed(ins[31:20]));
         7'h23: imm = 32'($signed({ins[31:25], ins[11:7]}));
         7'h63: imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
         7'h37, 7'h17: imm = ins & 32'hFFFFF000;
         7'h6F: imm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
         default: ;
      endcase
      case (op)
         7'h33: begin
            alu = (f7 == 32 && f3 == 0) ? 4'd1 : (f7 == 32 && f3 == 5) ? 4'd7 : 4'(base[f3]);
            we = 1;
            ill = !(f7 == 0 || (f7 == 32 && f3 inside {3'd0, 3'd5}));
         end
         7'h13: begin
            alu = (f3 == 5 && ins[30]) ? 4'd7 : 4'(base[f3]);
            sb = 1; we = 1;
            ill = (f3 == 1 && f7 != 0) || (f3 == 5 && !(f7 inside {7'd0, 7'd32}));
         end
         7'h03: begin sb = 1; mrd = 1; we = 1; ill = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}); end
         7'h23: begin sb = 1; mwr = 1; ill = f3 > 2; end
         7'h63: begin br = 1; alu = 4'd1; ill = f3 inside {3'd2, 3'd3}; end
         7'h37: begin alu = 4'd10; sb = 1; we = 1; end
         7'h17: begin sa = 1; sb = 1; we = 1; end
         7'h6F: begin j = 1; sa = 1; sb = 1; we = 1; end
         7'h67: begin jr = 1; sb = 1; we = 1; end
         7'h0F, 7'h73: ;
         default: ill = 1;
      endcase
      if (ill) {alu, sa, sb, we, mrd, mwr, br, j, jr} = '0;
      if (ins[11:7] == 0) we = 0;
      return {1'b1, ins, pc - 32'd4, pc, ins[11:7], imm, f3, alu, sa, sb, we, mrd, mwr, br, j, jr, ill};
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [6:0]  ops [12] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h0F, 7'h73, 7'h00};
      logic [31:0] r = $urandom;
      int          k = $urandom_range(0, 11);
      int          s = $urandom_range(0, 3);
      r[6:0] = (k == 11) ? 7'($urandom) : ops[k];
      if (s == 0) r[31:25] = 7'd0;
      if (s == 1) r[31:25] = 7'd32;
      return r;
   endfunction

   task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic v, input logic s, input logic f);
      i_instr = ins; i_pc = pc; i_instr_valid = v; i_stall = s; i_flush = f;
   endtask

   task automatic cycle();
      logic [149:0] nxt;
      nxt = i_flush ? BUB : i_stall ? expq : i_instr_valid ? ref_dec(i_instr, i_pc) : BUB;
      @(posedge i_clk);
      #1;
      expq = nxt;
   endtask

   task automatic test_reset();
      i_rstn = 1'b0;
      drive(32'h00500093, 32'h104, 1, 0, 0);
      #12;
      checks++;
      if (obs !== BUB) begin errors++; $display("FAIL reset_state got=%h want=%h", obs, BUB); end
      expq = BUB;
      @(negedge i_clk);
      i_rstn = 1'b1;
   endtask

   task automatic test_addi();
      drive(32'h00500093, 32'h104, 1, 0, 0);
      cycle();
      checks++;
      if ({o_valid, o_rd_addr, o_imm, o_alu_op, o_src_b_imm, o_reg_we, o_pc, o_link} !==
          {1'b1, 5'd1, 32'd5, 4'd0, 1'b1, 1'b1, 32'h100, 32'h104}) begin
         errors++;
         $display("FAIL addi_fields got v=%b rd=%0d imm=%h alu=%0d sb=%b we=%b pc=%h link=%h want 1 1 00000005 0 1 1 00000100 00000104",
                  o_valid, o_rd_addr, o_imm, o_alu_op, o_src_b_imm, o_reg_we, o_pc, o_link);
      end
      checks++;
      if ((obs & keep(expq)) !== (expq & keep(expq))) begin errors++; $display("FAIL addi_full got=%h want=%h", obs, expq); end
   endtask

   task automatic test_branch();
      drive(32'hFE208CE3, 32'h204, 1, 0, 0);
      #1;
      checks++;
      if ({o_rs1_addr, o_rs2_addr} !== {5'd1, 5'd2}) begin
         errors++; $display("FAIL beq_rs_addr got rs1=%0d rs2=%0d want rs1=1 rs2=2", o_rs1_addr, o_rs2_addr);
      end
      cycle();
      checks++;
      if ({o_imm, o_branch, o_funct3, o_alu_op, o_reg_we} !== {32'hFFFFFFF8, 1'b1, 3'd0, 4'd1, 1'b0}) begin
         errors++;
         $display("FAIL beq_fields got imm=%h br=%b f3=%0d alu=%0d we=%b want fffffff8 1 0 1 0", o_imm, o_branch, o_funct3, o_alu_op, o_reg_we);
      end
      checks++;
      if ((obs & keep(expq)) !== (expq & keep(expq))) begin errors++; $display("FAIL beq_full got=%h want=%h", obs, expq); end
   endtask

   task automatic test_lui_nop();
      drive(32'h123452B7, 32'h300, 1, 0, 0);
      cycle();
      checks++;
      if ({o_imm, o_alu_op, o_rd_addr} !== {32'h12345000, 4'd10, 5'd5}) begin
         errors++; $display("FAIL lui_fields got imm=%h alu=%0d rd=%0d want 12345000 10 5", o_imm, o_alu_op, o_rd_addr);
      end
      drive(32'h00000033, 32'h304, 1, 0, 0);
      cycle();
      checks++;
      if ({o_valid, o_reg_we, o_illegal} !== 3'b100) begin
         errors++; $display("FAIL nop_fields got v=%b we=%b ill=%b want 1 0 0", o_valid, o_reg_we, o_illegal);
      end
   endtask

   task automatic test_stall_flush();
      drive(32'h00500093, 32'h104, 1, 0, 0);
      cycle();
      held = obs;
      for (int n = 0; n < 3; n++) begin
         drive(rand_instr(), $urandom, 1, 1, 0);
         cycle();
         checks++;
         if (obs !== held) begin errors++; $display("FAIL stall_hold%0d got=%h want=%h", n, obs, held); end
      end
      drive(32'h00500093, 32'h108, 1, 1, 1);
      cycle();
      checks++;
      if (obs !== BUB) begin errors++; $display("FAIL flush_over_stall got=%h want=%h", obs, BUB); end
   endtask

   task automatic test_illegal();
      drive(32'hFFFFFFFF, 32'h400, 1, 0, 0);
      cycle();
      checks++;
      if ({o_illegal, o_valid, o_reg_we, o_mem_wr, o_mem_rd, o_branch, o_jal, o_jalr} !== 8'b11000000) begin
         errors++;
         $display("FAIL ill_ffffffff got ill=%b v=%b we=%b mw=%b mr=%b br=%b j=%b jr=%b want 1 1 0 0 0 0 0 0",
                  o_illegal, o_valid, o_reg_we, o_mem_wr, o_mem_rd, o_branch, o_jal, o_jalr);
      end
      drive(32'h40001013, 32'h404, 1, 0, 0);
      cycle();
      checks++;
      if ({o_illegal, o_valid, o_reg_we} !== 3'b110) begin
         errors++; $display("FAIL ill_slli got ill=%b v=%b we=%b want 1 1 0", o_illegal, o_valid, o_reg_we);
      end
   endtask

   task automatic test_boundary();
      drive(32'h00500093, 32'h0, 1, 0, 0);
      cycle();
      checks++;
      if (o_pc !== 32'hFFFFFFFC) begin errors++; $display("FAIL pc_wrap got=%h want=fffffffc", o_pc); end
      drive(32'h00002003, 32'h10, 1, 0, 0);
      cycle();
      checks++;
      if ({o_mem_rd, o_reg_we, o_valid} !== 3'b101) begin
         errors++; $display("FAIL load_x0 got mr=%b we=%b v=%b want 1 0 1", o_mem_rd, o_reg_we, o_valid);
      end
      drive(32'h00500093, 32'h14, 0, 0, 0);
      cycle();
      checks++;
      if (obs !== BUB) begin errors++; $display("FAIL invalid_bubble got=%h want=%h", obs, BUB); end
      drive(32'h00500093, 32'h18, 1, 0, 1);
      cycle();
      checks++;
      if (obs !== BUB) begin errors++; $display("FAIL flush_bubble got=%h want=%h", obs, BUB); end
   endtask

   task automatic test_reset_midstream();
      drive(32'h00500093, 32'h504, 1, 0, 0);
      cycle();
      #2;
      i_rstn = 1'b0;
      #1;
      checks++;
      if (obs !== BUB) begin errors++; $display("FAIL async_reset got=%h want=%h", obs, BUB); end
      expq = BUB;
      @(negedge i_clk);
      i_rstn = 1'b1;
      cycle();
      checks++;
      if ((obs & keep(expq)) !== (expq & keep(expq)) || o_valid !== 1'b1) begin
         errors++; $display("FAIL post_reset_capture got=%h want=%h", obs, expq);
      end
   endtask

   task automatic test_back_to_back();
      for (int n = 0; n < 400; n++) begin
         drive(rand_instr(), $urandom, $urandom_range(0, 7) != 0, $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0);
         #1;
         checks++;
         if ({o_rs1_addr, o_rs2_addr} !== {i_instr[19:15], i_instr[24:20]}) begin
            errors++; $display("FAIL rand_rs%0d got %0d %0d want %0d %0d", n, o_rs1_addr, o_rs2_addr, i_instr[19:15], i_instr[24:20]);
         end
         cycle();
         checks++;
         if ((obs & keep(expq)) !== (expq & keep(expq))) begin
            errors++; $display("FAIL rand%0d got=%h want=%h", n, obs, expq);
         end
      end
   endtask

   initial begin
      test_reset();
      test_addi();
      test_branch();
      test_lui_nop();
      test_stall_flush();
      test_illegal();
      test_boundary();
      test_reset_midstream();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/aukv_decode.md
Name: aukv_decode

Overview:
- Decode stage of the Auk-V RV32I 5-stage pipeline, directly downstream of the fetch unit.
- Consumes the fetch unit's instruction word, pc and valid, and decodes RV32I base opcodes into register addresses, a sign-extended immediate and execute/memory control bits.
- Registers the result into the decode/execute pipeline register.
- Presents rs1/rs2 addresses combinationally to the register file, so operand data aligns with the registered decode outputs.

Parameters:
- NOP_INSTR, 32'h00000033, bubble encoding (ADD x0,x0,x0), reported on o_instr when no valid instruction is held.

Ports:
- i_clk  in  1  clock.
- i_rstn  in  1  reset, asynchronous, active-low.
- i_pc  in  32  fetch pc: instruction address plus 4.
- i_instr  in  32  instruction word from fetch.
- i_instr_valid  in  1  i_instr is a real instruction.
- i_stall  in  1  hold the pipeline register.
- i_flush  in  1  branch taken or exception; kill the instruction being captured.
- o_rs1_addr  out  5  combinational i_instr[19:15], to register file.
- o_rs2_addr  out  5  combinational i_instr[24:20], to register file.
- o_valid  out  1  registered; stage holds a real instruction.
- o_instr  out  32  registered instruction word, or NOP_INSTR for a bubble.
- o_pc  out  32  registered instruction address (i_pc - 4).
- o_link  out  32  registered i_pc, the JAL/JALR return address.
- o_rd_addr  out  5  registered i_instr[11:7].
- o_imm  out  32  registered sign-extended immediate.
- o_funct3  out  3  registered i_instr[14:12]; branch condition and load/store size.
- o_alu_op  out  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B.
- o_src_a_pc  out  1  ALU operand A is o_pc (AUIPC, JAL).
- o_src_b_imm  out  1  ALU operand B is o_imm.
- o_reg_we  out  1  write rd.
- o_mem_rd  out  1  load.
- o_mem_wr  out  1  store.
- o_branch, o_jal, o_jalr  out  1 each  control-flow class.
- o_illegal  out  1  unsupported opcode/funct.

Behaviour:
- Reset: every registered output is 0, except o_instr = NOP_INSTR.
- Latency: 1 cycle. Capture occurs on the rising edge when i_stall=0.
- Priority per edge: i_flush > i_stall > capture.
  - i_flush=1: load a bubble regardless of i_stall.
  - i_stall=1 and i_flush=0: hold all registered outputs.
  - Otherwise, if i_instr_valid=0: load a bubble.
- Bubble contents: o_valid=0, o_instr=NOP_INSTR, all control bits 0, o_imm=0, addresses 0.
- Immediate selection by opcode[6:0]:
  - I-type (0010011, 0000011, 1100111, 1110011): instr[31:20] sign-extended.
  - S-type (0100011): {instr[31:25], instr[11:7]} sign-extended.
  - B-type (1100011): {instr[31], instr[7], instr[30:25], instr[11:8], 0} sign-extended.
  - U-type (0110111, 0010111): {instr[31:12], 12'b0}.
  - J-type (1101111): {instr[31], instr[19:12], instr[20], instr[30:21], 0} sign-extended.
  - All other opcodes: o_imm = 0.
- Decode by opcode:
  - OP (0110011): alu_op from funct3 plus funct7[5]. SUB/SRA need funct7=0100000; any other funct7 other than 0 is illegal.
  - OP-IMM: alu_op from funct3, src_b_imm=1. SRAI when instr[30]=1. Shift immediates with instr[31:25] not 0000000 or 0100000 are illegal.
  - LOAD: ADD, src_b_imm=1, mem_rd=1, reg_we=1. Legal funct3 are 0, 1, 2, 4, 5; others illegal.
  - STORE: ADD, src_b_imm=1, mem_wr=1, reg_we=0. Legal funct3 are 0–2; others illegal.
  - BRANCH: branch=1, alu_op SUB, reg_we=0. funct3 2 and 3 are illegal.
  - LUI: PASS_B, src_b_imm=1.
  - AUIPC: ADD, src_a_pc=1, src_b_imm=1.
  - JAL: jal=1, ADD, src_a_pc=1, src_b_imm=1, reg_we=1.
  - JALR: jalr=1, ADD, src_b_imm=1, reg_we=1.
  - MISC-MEM (0001111): decodes as NOP, valid=1.
  - SYSTEM: decodes as NOP, valid=1.
  - Anything else: o_illegal=1.
- Illegal instruction: o_valid=1, and reg_we, mem_rd, mem_wr, branch, jal, jalr are all 0.
- rd = x0: o_reg_we forced to 0. o_mem_rd is still asserted for loads.
- o_rs1_addr/o_rs2_addr are raw instruction fields even when the instruction is invalid; the register file ignores them.
- o_pc = i_pc - 32'd4, modulo 2^32 (i_pc=0 gives 0xFFFFFFFC).

Test Plan:
- Reset asserted mid-stream with a valid instr held → outputs immediately zero, o_instr=0x00000033, o_valid=0. First valid instr after release captured one edge later.
- i_instr=0x00500093 (ADDI x1,x0,5), i_pc=0x104 → next edge: o_valid=1, o_rd_addr=1, o_imm=5, o_alu_op=0, o_src_b_imm=1, o_reg_we=1, o_pc=0x100, o_link=0x104.
- i_instr=0xFE208CE3 (BEQ x1,x2,-8) → o_imm=0xFFFFFFF8, o_branch=1, o_funct3=0, o_alu_op=1, o_reg_we=0. Same cycle: o_rs1_addr=1, o_rs2_addr=2.
- i_instr=0x123452B7 (LUI x5) → o_imm=0x12345000, o_alu_op=10, o_rd_addr=5. i_instr=0x00000033 → o_valid=1, o_reg_we=0.
- Capture 0x00500093; then hold i_stall=1 for 3 cycles while changing i_instr → outputs unchanged. Assert i_flush with i_stall=1 → next edge bubble (o_valid=0).
- i_instr=0xFFFFFFFF → o_illegal=1, o_valid=1, o_reg_we=0, o_mem_wr=0. i_instr=0x40001013 (SLLI, bad funct7) → o_illegal=1.
